// File: rtl/bist_controller.sv
// BIST run sequencer: clears and steps the pattern counter, compacts each
// response into a MISR and compares the final signature with a golden value.
module bist_controller #(
    parameter int               CNT_W    = 8,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h8005,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'h0000
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] last_count_i,
    input  logic [SIG_W-1:0] golden_sig_i,
    input  logic [CNT_W-1:0] counter_i,
    input  logic [SIG_W-1:0] dut_resp_i,
    output logic             cnt_res_o,
    output logic             cnt_incr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             err_o,
    output logic [SIG_W-1:0] signature_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   misr_q, misr_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [SIG_W-1:0]   golden_q, golden_d;
    logic               pass_q, pass_d;
    logic               err_q, err_d;
    logic [SIG_W-1:0]   misr_step;

    // One MISR shift: feedback taps applied when the MSB falls out.
    always_comb begin
        misr_step = {misr_q[SIG_W-2:0], 1'b0}
                  ^ (misr_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ dut_resp_i;
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q  <= IDLE;
            misr_q   <= SIG_SEED;
            shadow_q <= '0;
            last_q   <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            misr_q   <= misr_d;
            shadow_q <= shadow_d;
            last_q   <= last_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        misr_d     = misr_q;
        shadow_d   = shadow_q;
        last_d     = last_q;
        golden_d   = golden_q;
        pass_d     = pass_q;
        err_d      = err_q;
        cnt_res_o  = 1'b0;
        cnt_incr_o = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i && !abort_i) begin
                    state_d  = CLEAR;
                    last_d   = last_count_i;
                    golden_d = golden_sig_i;
                    pass_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            CLEAR: begin
                cnt_res_o = 1'b1;
                misr_d    = SIG_SEED;
                shadow_d  = '0;
                state_d   = APPLY;
            end
            APPLY: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                misr_d = misr_step;
                // A counter that lost track of our index ends the run early.
                if (counter_i != shadow_q) begin
                    err_d   = 1'b1;
                    state_d = COMPARE;
                end else if (shadow_q == last_q) begin
                    state_d = COMPARE;
                end else begin
                    cnt_incr_o = 1'b1;
                    shadow_d   = shadow_q + CNT_W'(1);
                    state_d    = APPLY;
                end
            end
            COMPARE: begin
                pass_d  = (misr_q == golden_q) && !err_q;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort leaves the signature and the counter exactly where they were.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            misr_d     = misr_q;
            shadow_d   = shadow_q;
            last_d     = last_q;
            golden_d   = golden_q;
            pass_d     = 1'b0;
            err_d      = 1'b0;
            cnt_res_o  = 1'b0;
            cnt_incr_o = 1'b0;
        end
    end

    assign busy_o      = (state_q == CLEAR) || (state_q == APPLY) ||
                         (state_q == CAPTURE) || (state_q == COMPARE);
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign err_o       = err_q;
    assign signature_o = misr_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller; the bench models the pattern counter
// and a table-driven circuit-under-test response.
module tb_bist_controller;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  lastCount = '0;
    logic [15:0] goldenSig = '0;
    logic [7:0]  counter = 8'hAA;
    logic [15:0] dutResp;
    logic        cntRes, cntIncr, busy, done, pass, err;
    logic [15:0] signature;

    logic [15:0] respTable [256];
    logic        stuckZero = 1'b0;
    int          assertCount = 0;
    int          failCount = 0;
    int          incrPulses = 0;
    int          cycles;

    bist_controller dut (
        .clk_i        (clk),
        .res_i        (res),
        .start_i      (start),
        .abort_i      (abort),
        .last_count_i (lastCount),
        .golden_sig_i (goldenSig),
        .counter_i    (counter),
        .dut_resp_i   (dutResp),
        .cnt_res_o    (cntRes),
        .cnt_incr_o   (cntIncr),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .err_o        (err),
        .signature_o  (signature)
    );

    always #5 clk = ~clk;

    assign dutResp = respTable[counter];

    // Pattern counter as seen by the controller; stuckZero models a broken counter.
    always @(posedge clk) begin
        if (cntRes) counter <= 8'd0;
        else if (cntIncr && !stuckZero) counter <= counter + 8'd1;
        if (cntIncr) incrPulses++;
    end

    always @(negedge clk) begin
        if (cntRes && cntIncr) checkOutput("exclusiveCtl", 32'(cntRes & cntIncr), 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic fillResp(input logic [15:0] value);
        for (int i = 0; i < 256; i++) respTable[i] = value;
    endtask

    // Pulses start for one edge, then scrambles the run inputs to show they are latched.
    task automatic pulseStart(input logic [7:0] last, input logic [15:0] golden);
        @(negedge clk);
        start      = 1'b1;
        lastCount  = last;
        goldenSig  = golden;
        incrPulses = 0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lastCount = ~last;
        goldenSig = ~golden;
        checkOutput("clearPulse", 32'(cntRes), 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] last, input logic [15:0] golden, output int nCycles);
        pulseStart(last, golden);
        nCycles = 0;
        while (!done && nCycles < 2000) begin
            @(posedge clk);
            #1;
            nCycles++;
        end
    endtask

    initial begin
        fillResp(16'h0000);

        // Reset values
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstPass", 32'(pass), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstCtl", 32'({cntRes, cntIncr}), 32'd0);
        checkOutput("rstSig", 32'(signature), 32'h0000);

        // Single pattern
        respTable[0] = 16'h0001;
        applyStimulus(8'd0, 16'h0001, cycles);
        checkOutput("t1Cycles", 32'(cycles), 32'd4);
        checkOutput("t1Sig", 32'(signature), 32'h0001);
        checkOutput("t1Pass", 32'(pass), 32'd1);
        checkOutput("t1Incr", 32'(incrPulses), 32'd0);

        // Two patterns exercising the feedback taps
        fillResp(16'h0000);
        respTable[0] = 16'h8000;
        applyStimulus(8'd1, 16'h8005, cycles);
        checkOutput("t2Cycles", 32'(cycles), 32'd6);
        checkOutput("t2Sig", 32'(signature), 32'h8005);
        checkOutput("t2Pass", 32'(pass), 32'd1);
        checkOutput("t2Incr", 32'(incrPulses), 32'd1);

        // Abort from DONE clears the result but keeps the signature
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abDoneDone", 32'(done), 32'd0);
        checkOutput("abDonePass", 32'(pass), 32'd0);
        checkOutput("abDoneSig", 32'(signature), 32'h8005);

        applyStimulus(8'd1, 16'h8004, cycles);
        checkOutput("t2bDone", 32'(done), 32'd1);
        checkOutput("t2bPass", 32'(pass), 32'd0);
        checkOutput("t2bErr", 32'(err), 32'd0);

        // Full 256-pattern run, counter must stop at 0xFF
        fillResp(16'h0000);
        applyStimulus(8'hFF, 16'h0000, cycles);
        checkOutput("t3Cycles", 32'(cycles), 32'd514);
        checkOutput("t3Counter", 32'(counter), 32'hFF);
        checkOutput("t3Incr", 32'(incrPulses), 32'd255);
        checkOutput("t3Sig", 32'(signature), 32'h0000);
        checkOutput("t3Pass", 32'(pass), 32'd1);

        // Counter stuck at zero: error at the second capture
        stuckZero = 1'b1;
        applyStimulus(8'd3, 16'h0000, cycles);
        checkOutput("t4Cycles", 32'(cycles), 32'd6);
        checkOutput("t4Err", 32'(err), 32'd1);
        checkOutput("t4Pass", 32'(pass), 32'd0);
        stuckZero = 1'b0;

        // Abort in APPLY of pattern 5
        for (int i = 0; i < 256; i++) respTable[i] = 16'(i + 1);
        pulseStart(8'd10, 16'h0000);
        repeat (11) @(posedge clk);
        #1;
        checkOutput("t5BusyPre", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("t5Busy", 32'(busy), 32'd0);
        checkOutput("t5Done", 32'(done), 32'd0);
        checkOutput("t5Err", 32'(err), 32'd0);
        checkOutput("t5Counter", 32'(counter), 32'd5);
        checkOutput("t5Sig", 32'(signature), 32'h0001);
        repeat (3) @(posedge clk);
        #1 checkOutput("t5Stay", 32'(busy), 32'd0);

        // Start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("t5bBusy", 32'(busy), 32'd0);
        checkOutput("t5bClr", 32'(cntRes), 32'd0);
        @(posedge clk);
        #1 checkOutput("t5bBusy2", 32'(busy), 32'd0);

        // Asynchronous reset during the second CAPTURE
        fillResp(16'h1234);
        pulseStart(8'd3, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6SigPre", 32'(signature), 32'h1234);
        checkOutput("t6IncrPre", 32'(cntIncr), 32'd1);
        #1 res = 1'b1;
        #1;
        checkOutput("t6Busy", 32'(busy), 32'd0);
        checkOutput("t6Sig", 32'(signature), 32'h0000);
        checkOutput("t6Incr", 32'(cntIncr), 32'd0);
        checkOutput("t6Counter", 32'(counter), 32'd1);
        #1 res = 1'b0;

        applyStimulus(8'd2, 16'h7E8C, cycles);
        checkOutput("t6bCycles", 32'(cycles), 32'd8);
        checkOutput("t6bSig", 32'(signature), 32'h7E8C);
        checkOutput("t6bPass", 32'(pass), 32'd1);
        checkOutput("t6bErr", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
